// File: rtl/dda_cmd_if.sv
// dda_cmd_if: UART byte stream in, published parameter set and frame status out.
interface dda_cmd_if #(parameter int REG_SIZE = 10);
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  rx_error;
  logic [REG_SIZE*8-1:0] cfg_data;
  logic                  cfg_valid;
  logic                  frame_err;
  logic [1:0]            err_code;
  logic                  busy;
  modport master (output rx_valid, rx_byte, rx_error, input cfg_data, cfg_valid, frame_err, err_code, busy);
  modport slave (input rx_valid, rx_byte, rx_error, output cfg_data, cfg_valid, frame_err, err_code, busy);
endinterface

// File: rtl/dda_cmd_framer.sv
// dda_cmd_framer: checks SYNC/LEN/payload/XOR frames and publishes the payload atomically.
module dda_cmd_framer #(
  parameter int         REG_SIZE    = 10,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 5000
) (
  input logic     clk,
  input logic     rst_n,
  dda_cmd_if.slave bus
);
  localparam int IW = $clog2(REG_SIZE + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int DW = REG_SIZE * 8;
  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} state_t;
  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    csum;
  logic [TW-1:0] tmr;
  logic [DW-1:0] shadow;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;
  logic          frame_err;
  logic [1:0]    err_code;
  logic          active;
  logic          take;
  assign active = state != IDLE;
  assign take   = bus.rx_valid && !bus.rx_error;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      csum      <= '0;
      tmr       <= '0;
      shadow    <= '0;
      cfg_data  <= '0;
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      // A UART error beats a simultaneous byte; the byte is thrown away
      if (active && bus.rx_error) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        err_code  <= 2'd3;
      end else if (take) begin
        tmr <= TW'(TIMEOUT_CYC);
        if (state == IDLE) begin
          if (bus.rx_byte == SYNC_BYTE) state <= LEN;
        end else if (state == LEN) begin
          if (bus.rx_byte == 8'(REG_SIZE)) begin
            state <= PAYLOAD;
            idx   <= '0;
            csum  <= bus.rx_byte;
          end else begin
            state     <= IDLE;
            frame_err <= 1'b1;
            err_code  <= 2'd1;
          end
        end else if (state == PAYLOAD) begin
          shadow[DW-1-8*int'(idx) -: 8] <= bus.rx_byte;
          csum <= csum ^ bus.rx_byte;
          idx  <= idx + 1'b1;
          if (idx == IW'(REG_SIZE - 1)) state <= CSUM;
        end else begin
          state <= IDLE;
          if (bus.rx_byte == csum) begin
            cfg_data  <= shadow;
            cfg_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            err_code  <= 2'd2;
          end
        end
      end else if (active) begin
        // Expires on the cycle the count would hit zero; a byte on that edge wins above
        if (tmr <= TW'(1)) begin
          state     <= IDLE;
          tmr       <= '0;
          frame_err <= 1'b1;
          err_code  <= 2'd3;
        end else begin
          tmr <= tmr - 1'b1;
        end
      end
    end
  end
  assign bus.cfg_data  = cfg_data;
  assign bus.cfg_valid = cfg_valid;
  assign bus.frame_err = frame_err;
  assign bus.err_code  = err_code;
  assign bus.busy      = active;
endmodule

// File: tb/tb_dda_cmd_framer.sv
// tb_dda_cmd_framer: frame vectors plus corner sequences, checked by a pulse scoreboard.
module tb_dda_cmd_framer;
  localparam int RS = 10;
  localparam int TO = 5000;
  localparam int DW = RS * 8;
  typedef struct {
    logic          is_err;
    logic [1:0]    code;
    logic [DW-1:0] data;
  } ev_t;
  typedef struct {
    logic [7:0]    len;
    logic [DW-1:0] pay;
    logic [7:0]    flip;
    int            gap;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ev_t sb[$];
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] mcfg = '0;
  logic [1:0] mcode = 2'd0;
  logic [DW-1:0] prev_cfg = '0;
  logic prev_rst = 1'b0;
  vec_t tbl[8];
  dda_cmd_if #(.REG_SIZE(RS)) bus ();
  dda_cmd_framer #(.REG_SIZE(RS), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && prev_rst && bus.cfg_data !== prev_cfg) check("cfg_data_moved_without_valid", DW'(bus.cfg_valid), DW'(1));
    if (rst_n && (bus.cfg_valid || bus.frame_err)) begin
      check("pulse_exclusive", DW'(bus.cfg_valid & bus.frame_err), '0);
      if (sb.size() == 0) check("unexpected_pulse", DW'({bus.cfg_valid, bus.frame_err}), '0);
      else begin
        ev_t e;
        e = sb.pop_front();
        check("frame_err", DW'(bus.frame_err), DW'(e.is_err));
        check("cfg_valid", DW'(bus.cfg_valid), DW'(!e.is_err));
        check("err_code", DW'(bus.err_code), DW'(e.code));
        check("cfg_data", bus.cfg_data, e.data);
      end
    end
    prev_cfg = bus.cfg_data;
    prev_rst = rst_n;
  end
  function automatic logic [7:0] cks(input logic [7:0] len, input logic [DW-1:0] pay);
    logic [7:0] c;
    c = len;
    for (int i = 0; i < RS; i++) c ^= pay[DW-1-8*i -: 8];
    return c;
  endfunction
  task automatic push();
    ev_t v;
    v.is_err = 1'b0;
    v.code = mcode;
    v.data = mcfg;
    sb.push_back(v);
  endtask
  task automatic expect_err(input logic [1:0] code);
    mcode = code;
    push();
    sb[sb.size()-1].is_err = 1'b1;
  endtask
  task automatic expect_ok(input logic [DW-1:0] data);
    mcfg = data;
    push();
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_byte = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic frame(input logic [7:0] len, input logic [DW-1:0] pay, input logic [7:0] flip, input int gap);
    if (len != 8'(RS)) expect_err(2'd1);
    else if (flip != 8'h00) expect_err(2'd2);
    else expect_ok(pay);
    send(8'hA5, gap);
    send(len, gap);
    if (len == 8'(RS)) begin
      for (int i = 0; i < RS; i++) send(pay[DW-1-8*i -: 8], gap);
      send(cks(len, pay) ^ flip, gap);
    end
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check(nm, DW'(sb.size()), '0);
    sb.delete();
  endtask
  task automatic partial(input int n);
    send(8'hA5, 0);
    send(8'(RS), 0);
    for (int i = 0; i < n; i++) send(8'(8'h30 + i), 0);
  endtask
  initial begin
    tbl[0] = '{8'h0A, 80'h0010_0020_0100_0080_0004, 8'h00, 0};
    tbl[1] = '{8'h0A, 80'h0010_0020_0100_0080_0004, 8'h01, 0};
    tbl[2] = '{8'h09, 80'h0, 8'h00, 0};
    tbl[3] = '{8'hA5, 80'h0, 8'h00, 0};
    tbl[4] = '{8'h0B, 80'h0, 8'h00, 1};
    tbl[5] = '{8'h0A, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 8'h80, 0};
    tbl[6] = '{8'h0A, 80'h0123_4567_89AB_CDEF_A55A, 8'h00, 2};
    tbl[7] = '{8'h0A, 80'h0, 8'h00, 0};
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;
    bus.rx_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cfg_data", bus.cfg_data, '0);
    check("reset_err_code", DW'(bus.err_code), '0);
    check("reset_busy", DW'(bus.busy), '0);
    check("reset_pulses", DW'({bus.cfg_valid, bus.frame_err}), '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      frame(tbl[i].len, tbl[i].pay, tbl[i].flip, tbl[i].gap);
      drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_busy_after", i), DW'(bus.busy), '0);
      check($sformatf("vec%0d_cfg_hold", i), bus.cfg_data, mcfg);
    end
    frame(8'h09, '0, 8'h00, 0);
    frame(8'h0A, 80'hAAAA_5555_0000_1111_2222, 8'h00, 0);
    drain("badlen_then_good");
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h5A, 0);
    frame(8'h0A, 80'h1111_2222_3333_4444_5555, 8'h00, 0);
    drain("garbage_then_good");
    expect_err(2'd3);
    partial(4);
    check("busy_mid_frame", DW'(bus.busy), DW'(1));
    repeat (TO + 2) begin
      @(posedge clk);
      #1;
    end
    check("busy_after_timeout", DW'(bus.busy), '0);
    drain("timeout");
    frame(8'h0A, 80'h9999_8888_7777_6666_5555, 8'h00, 0);
    drain("good_after_timeout");
    expect_err(2'd3);
    partial(3);
    bus.rx_error = 1'b1;
    @(posedge clk);
    #1 bus.rx_error = 1'b0;
    drain("rx_error_payload");
    expect_err(2'd3);
    partial(2);
    bus.rx_error = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte = 8'hA5;
    @(posedge clk);
    #1;
    bus.rx_error = 1'b0;
    bus.rx_valid = 1'b0;
    frame(8'h0A, 80'h0F0F_F0F0_1234_5678_9ABC, 8'h00, 0);
    drain("err_with_byte_then_good");
    bus.rx_error = 1'b1;
    @(posedge clk);
    #1 bus.rx_error = 1'b0;
    drain("rx_error_idle_ignored");
    partial(3);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mcfg = '0;
    mcode = 2'd0;
    check("midreset_cfg_data", bus.cfg_data, '0);
    check("midreset_busy", DW'(bus.busy), '0);
    check("midreset_err_code", DW'(bus.err_code), '0);
    drain("midreset_no_pulse");
    frame(8'h0A, 80'hDEAD_BEEF_CAFE_F00D_0102, 8'h00, 0);
    frame(8'h0A, 80'h0203_0405_0607_0809_0A0B, 8'h00, 0);
    drain("back_to_back");
    check("final_cfg_data", bus.cfg_data, 80'h0203_0405_0607_0809_0A0B);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
